// File: rtl/pwm_pkg.sv
// Shared constants for the PWM bank: bus widths and register addresses.
// CMP registers occupy addresses 0..NUM_CH-1; the control registers sit at 0x8..0xB.
package pwm_pkg;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned WDATA_W = 12;

    localparam logic [ADDR_W-1:0] ADDR_PRESC = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_TOP   = 4'h9;
    localparam logic [ADDR_W-1:0] ADDR_CHEN  = 4'hA;
    localparam logic [ADDR_W-1:0] ADDR_POL   = 4'hB;

endpackage

// File: rtl/pwm_bank_if.sv
// Decoded register-write bus from the SPI word decoder into the PWM bank.
//   wr_valid : one-cycle write strobe
//   wr_addr  : register address
//   wr_data  : write data
interface pwm_bank_if;
    import pwm_pkg::*;

    logic               wr_valid;
    logic [ADDR_W-1:0]  wr_addr;
    logic [WDATA_W-1:0] wr_data;

    modport master (output wr_valid, wr_addr, wr_data);
    modport slave  (input  wr_valid, wr_addr, wr_data);

endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter and reload strobe, with
// double-buffered TOP/PRESC registers.
//   clk, rst           : clock, async active-high reset
//   en                 : run enable; while low, counters hold at 0 and actives track shadows
//   top_we/top_data    : TOP shadow write
//   presc_we/presc_data: PRESC shadow write
//   cnt                : period counter
//   load_c             : combinational "active <= shadow" strobe (reload or idle)
//   tick, period_start : registered prescaler tick and reload pulse
module pwm_timebase #(
    parameter int unsigned PWM_WIDTH   = 10,
    parameter int unsigned PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   top_we,
    input  logic [PWM_WIDTH-1:0]   top_data,
    input  logic                   presc_we,
    input  logic [PRESC_WIDTH-1:0] presc_data,
    output logic [PWM_WIDTH-1:0]   cnt,
    output logic                   load_c,
    output logic                   tick,
    output logic                   period_start
);

    logic [PWM_WIDTH-1:0]   top_sh;
    logic [PWM_WIDTH-1:0]   top_act;
    logic [PRESC_WIDTH-1:0] presc_sh;
    logic [PRESC_WIDTH-1:0] presc_act;
    logic [PRESC_WIDTH-1:0] pc;
    logic                   tick_c;
    logic                   reload_c;

    assign tick_c   = en && (pc == presc_act);
    assign reload_c = tick_c && (cnt == top_act);
    assign load_c   = reload_c || !en;

    // Shadow registers take writes immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_sh   <= '1;
            presc_sh <= '0;
        end else begin
            if (top_we)   top_sh   <= top_data;
            if (presc_we) presc_sh <= presc_data;
        end
    end

    // Prescaler, counter and active-copy reload; a same-cycle write is not seen
    // by the reload because the shadow still holds its old value here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= '0;
            cnt          <= '0;
            tick         <= 1'b0;
            period_start <= 1'b0;
            top_act      <= '1;
            presc_act    <= '0;
        end else begin
            tick         <= tick_c;
            period_start <= reload_c;
            if (!en) begin
                pc  <= '0;
                cnt <= '0;
            end else if (tick_c) begin
                pc  <= '0;
                cnt <= reload_c ? '0 : cnt + PWM_WIDTH'(1);
            end else begin
                pc  <= pc + PRESC_WIDTH'(1);
            end
            if (load_c) begin
                top_act   <= top_sh;
                presc_act <= presc_sh;
            end
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator with shared timebase, per-channel enable and
// polarity, and compare values double-buffered to the period boundary.
//   clk, rst     : clock, async active-high reset
//   en           : global run enable
//   bus          : register-write bus (slave)
//   pwm_out      : registered PWM outputs
//   period_start : one-cycle pulse on each counter reload
//   tick         : prescaler tick
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned PWM_WIDTH   = 10,
    parameter int unsigned PRESC_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    pwm_bank_if.slave         bus,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic              tick
);

    logic [PWM_WIDTH-1:0] cnt;
    logic                 load_c;
    logic [NUM_CH-1:0]    ch_en;
    logic [NUM_CH-1:0]    pol;
    logic [NUM_CH-1:0]    pwm_nxt_c;
    logic                 unused_wr_data;

    // Not every data bit feeds a register for every parameter choice
    assign unused_wr_data = ^bus.wr_data;

    pwm_timebase #(
        .PWM_WIDTH   (PWM_WIDTH),
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .top_we       (bus.wr_valid && (bus.wr_addr == ADDR_TOP)),
        .top_data     (bus.wr_data[PWM_WIDTH-1:0]),
        .presc_we     (bus.wr_valid && (bus.wr_addr == ADDR_PRESC)),
        .presc_data   (bus.wr_data[PRESC_WIDTH-1:0]),
        .cnt          (cnt),
        .load_c       (load_c),
        .tick         (tick),
        .period_start (period_start)
    );

    // Channel enable and polarity apply without buffering
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_en <= '0;
            pol   <= '0;
        end else if (bus.wr_valid) begin
            if (bus.wr_addr == ADDR_CHEN) ch_en <= bus.wr_data[NUM_CH-1:0];
            if (bus.wr_addr == ADDR_POL)  pol   <= bus.wr_data[NUM_CH-1:0];
        end
    end

    // Per-channel compare shadow/active pair and output function
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [PWM_WIDTH-1:0] cmp_sh;
        logic [PWM_WIDTH-1:0] cmp_act;
        logic                 cmp_we;

        assign cmp_we = bus.wr_valid && (bus.wr_addr == ADDR_W'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cmp_sh  <= '0;
                cmp_act <= '0;
            end else begin
                if (cmp_we) cmp_sh  <= bus.wr_data[PWM_WIDTH-1:0];
                if (load_c) cmp_act <= cmp_sh;
            end
        end

        assign pwm_nxt_c[i] = (en && ch_en[i]) ? ((cnt < cmp_act) ^ pol[i]) : pol[i];
    end

    // Output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_out <= '0;
        else     pwm_out <= pwm_nxt_c;
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank (NUM_CH = 4, PWM_WIDTH = 10, PRESC_WIDTH = 4).
module tb_pwm_bank;
    import pwm_pkg::*;

    localparam int unsigned NCH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [NCH-1:0] pwm_out;
    logic           period_start;
    logic           tick;

    int total = 0;
    int bad   = 0;
    int h, l, p, t;
    bit seen;

    pwm_bank_if bus ();

    pwm_bank #(
        .NUM_CH      (NCH),
        .PWM_WIDTH   (10),
        .PRESC_WIDTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .bus          (bus),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write is taken on the following posedge
    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_ps(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            ok = period_start;
        end
        check(tag, int'(ok), 1);
    endtask

    // Starts on a period_start negedge, samples until the next one; optionally
    // issues a write on sample number 'off'.
    task automatic measure(input bit do_wr, input int off, input logic [3:0] a,
                           input logic [11:0] d, output int highs, output int len);
        highs = 0;
        len   = 0;
        do begin
            @(negedge clk);
            bus.wr_valid = 1'b0;
            len++;
            highs += int'(pwm_out[0]);
            if (do_wr && len == off) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = a;
                bus.wr_data  = d;
            end
        end while (!period_start && len < 5000);
        bus.wr_valid = 1'b0;
    endtask

    task automatic sample_n(input int n, output int highs, output int ps, output int tk);
        highs = 0;
        ps    = 0;
        tk    = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            highs += int'(pwm_out[0]);
            ps    += int'(period_start);
            tk    += int'(tick);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        repeat (3) @(negedge clk);
        check("rst pwm", int'(pwm_out), 0);
        check("rst ps", int'(period_start), 0);
        check("rst tick", int'(tick), 0);
        rst = 1'b0;

        // Basic 3/10 waveform
        wr(ADDR_TOP, 12'd9);
        wr(4'h0, 12'd3);
        wr(ADDR_CHEN, 12'h001);
        wr(ADDR_PRESC, 12'd0);
        check("idle pwm", int'(pwm_out), 0);
        check("idle tick", int'(tick), 0);
        en = 1'b1;
        @(negedge clk);
        check("first tick", int'(tick), 1);
        check("first tick ps", int'(period_start), 0);
        wait_ps("ps base");
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("base high", h, 3);
        check("base len", l, 10);

        // Mid-period write: deferred to next period
        measure(1'b1, 2, 4'h0, 12'd7, h, l);
        check("midwr cur", h, 3);
        check("midwr len", l, 10);
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("midwr next", h, 7);

        // Write on the reload edge: deferred one further period
        measure(1'b1, 9, 4'h0, 12'd3, h, l);
        check("rlwr cur", h, 7);
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("rlwr deferred", h, 7);
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("rlwr applied", h, 3);

        // Duty extremes
        wr(4'h0, 12'd0);
        wait_ps("ps cmp0");
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("cmp0 high", h, 0);
        check("cmp0 len", l, 10);
        wr(4'h0, 12'd10);
        wait_ps("ps cmp10");
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("cmp top+1 high", h, 10);
        wr(4'h0, 12'h3FF);
        wait_ps("ps cmpmax");
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("cmp max high", h, 10);

        // TOP = 0
        wr(ADDR_TOP, 12'd0);
        wr(4'h0, 12'd1);
        wait_ps("ps top0");
        sample_n(8, h, p, t);
        check("top0 high", h, 8);
        check("top0 ps", p, 8);

        // Polarity, idle level and 2-clk latency
        wr(ADDR_CHEN, 12'h000);
        wr(ADDR_TOP, 12'd9);
        wr(4'h0, 12'd3);
        @(negedge clk);
        @(negedge clk);
        check("dis low", int'(pwm_out), 0);
        wr(ADDR_POL, 12'h001);
        check("pol lat1", int'(pwm_out[0]), 0);
        @(negedge clk);
        check("pol lat2", int'(pwm_out), 1);
        sample_n(10, h, p, t);
        check("pol idle", h, 10);
        wr(ADDR_CHEN, 12'h001);
        wait_ps("ps inv");
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("inv high", h, 7);
        check("inv len", l, 10);

        // Unmapped addresses
        wr(4'h5, 12'd1);
        wr(4'hF, 12'hFFF);
        wr(4'hC, 12'h000);
        wait_ps("ps ign");
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("ign high", h, 7);
        check("ign len", l, 10);
        check("ign other ch", int'(pwm_out[3:1]), 0);

        // Prescaler
        wr(ADDR_POL, 12'h000);
        wr(ADDR_PRESC, 12'd3);
        wr(ADDR_TOP, 12'd3);
        wr(4'h0, 12'd2);
        wait_ps("ps presc");
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("presc high", h, 8);
        check("presc len", l, 16);
        sample_n(16, h, p, t);
        check("presc ticks", t, 4);
        check("presc ps", p, 1);

        // Async reset mid-period while output high
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = pwm_out[0];
        end
        check("pre-rst high", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        check("rst async pwm", int'(pwm_out), 0);
        check("rst async tick", int'(tick), 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wr(4'h0, 12'd512);
        wr(ADDR_CHEN, 12'h001);
        check("post-rst pwm", int'(pwm_out), 0);
        en = 1'b1;
        wait_ps("ps 1024");
        measure(1'b0, 0, 4'h0, 12'd0, h, l);
        check("reset top len", l, 1024);
        check("reset top high", h, 512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
